// File: rtl/kypd_pkg.sv
// Shared types and constants for the PmodKYPD column scanner.
package kypd_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_class_t;
  typedef enum logic {ST_IDLE, ST_PRESSED} kypd_state_t;

  // Hex code of each key, indexed [row][col]
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/kypd_debounce.sv
// Frame-level debounce: accepts a press/release after DEBOUNCE_FRAMES identical frames.
module kypd_debounce
  import kypd_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         frame_valid,
  input  frame_class_t frame_cls,
  input  logic [3:0]   frame_code,
  output logic [3:0]   key_code,
  output logic         key_held,
  output logic         key_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  kypd_state_t        r_state, w_state_nxt;
  frame_class_t       r_prev_cls;
  logic [3:0]         r_prev_code;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_code, w_code_nxt;
  logic               r_press, w_press_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev_cls  <= FR_NONE;
      r_prev_code <= 4'h0;
      r_cnt       <= '0;
      r_code      <= 4'h0;
      r_press     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_press <= w_press_nxt;
      if (frame_valid) begin
        r_prev_cls  <= frame_cls;
        r_prev_code <= frame_code;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_press_nxt = 1'b0;
    if (frame_valid) begin
      if (frame_cls == r_prev_cls && frame_code == r_prev_code)
        w_cnt_nxt = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;
      else
        w_cnt_nxt = CNT_W'(1);
      // MULTI falls through both branches: it only disturbs stability
      if (w_cnt_nxt == CNT_MAX) begin
        case (r_state)
          ST_IDLE:
            if (frame_cls == FR_SINGLE) begin
              w_state_nxt = ST_PRESSED;
              w_code_nxt  = frame_code;
              w_press_nxt = 1'b1;
            end
          ST_PRESSED:
            if (frame_cls == FR_NONE) begin
              w_state_nxt = ST_IDLE;
            end else if (frame_cls == FR_SINGLE && frame_code != r_code) begin
              w_code_nxt  = frame_code;
              w_press_nxt = 1'b1;
            end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  assign key_code  = r_code;
  assign key_held  = (r_state == ST_PRESSED);
  assign key_press = r_press;

endmodule

// File: rtl/kypd_scanner.sv
// PmodKYPD scanner: row synchroniser, column divider/rotation and per-frame classifier.
module kypd_scanner
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic       key_press
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [3:0]                         r_row_s1, r_row_s2;
  logic [DIV_W-1:0]                   r_div;
  logic [1:0]                         r_col_idx;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  r_acc;   // [col][row], 1 = key down
  logic                               r_frame_valid;
  logic                               w_tick;
  logic                               w_any, w_multi;
  logic [3:0]                         w_hit_code, w_code;
  frame_class_t                       w_cls;

  assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_s1      <= 4'hF;
      r_row_s2      <= 4'hF;
      r_div         <= '0;
      r_col_idx     <= 2'd0;
      r_acc         <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      r_row_s1      <= row;
      r_row_s2      <= r_row_s1;
      r_frame_valid <= w_tick && (r_col_idx == 2'd3);
      if (w_tick) begin
        r_div            <= '0;
        r_col_idx        <= r_col_idx + 2'd1;
        r_acc[r_col_idx] <= ~r_row_s2;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign col = ~(4'b0001 << r_col_idx);

  // Non-SINGLE frames carry code 0 so candidate equality is class-driven
  always_comb begin
    w_any      = 1'b0;
    w_multi    = 1'b0;
    w_hit_code = 4'h0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (r_acc[c][r]) begin
          if (w_any) w_multi = 1'b1;
          w_any      = 1'b1;
          w_hit_code = KEY_MAP[r][c];
        end
      end
    end
    w_cls  = w_multi ? FR_MULTI : (w_any ? FR_SINGLE : FR_NONE);
    w_code = (w_cls == FR_SINGLE) ? w_hit_code : 4'h0;
  end

  kypd_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_valid(r_frame_valid),
    .frame_cls  (w_cls),
    .frame_code (w_code),
    .key_code   (key_code),
    .key_held   (key_held),
    .key_press  (key_press)
  );

endmodule

// File: tb/tb_kypd_scanner.sv
// Bench for kypd_scanner: keypad model, frame-level reference model, per-cycle checks.
module tb_kypd_scanner;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_held, key_press;
  logic [15:0] keys = '0;   // bit r*4+c = key [r][c] down

  always #5 clk = ~clk;

  kypd_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_held(key_held), .key_press(key_press)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(keys[r*4 +: 4] & ~col)) row[r] = 1'b0;
  end

  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  // reference model state
  int          n, cnt, prev_cand, pulses;
  logic [15:0] h0, h1, samp;
  bit          frame_due, m_held, e_press;
  logic [3:0]  e_code;
  int          checks = 0, errors = 0;

  // -1 = no key, -2 = several keys, else hex code
  function automatic int classify(input logic [15:0] s);
    if ($countones(s) == 0) return -1;
    if ($countones(s) > 1) return -2;
    for (int i = 0; i < 16; i++) if (s[i]) return kmap[i];
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    int cand, j;
    logic [3:0] exp_col;
    @(posedge clk);
    if (rst) begin
      n = 0; h0 = '0; h1 = '0; samp = '0; frame_due = 0;
      prev_cand = -3; cnt = 0; m_held = 0; e_code = 4'h0; e_press = 0;
    end else begin
      n++;
      e_press = 0;
      if (frame_due) begin
        frame_due = 0;
        cand = classify(samp);
        cnt = (cand == prev_cand) ? ((cnt < DF) ? cnt + 1 : DF) : 1;
        prev_cand = cand;
        if (cnt == DF) begin
          if (cand >= 0 && (!m_held || cand != int'(e_code))) begin
            m_held = 1; e_code = 4'(cand); e_press = 1;
          end else if (cand == -1) begin
            m_held = 0;
          end
        end
      end
      // column j is sampled from the keypad as seen two edges earlier
      if (n % SD == 0) begin
        j = ((n - 1) / SD) % 4;
        for (int r = 0; r < 4; r++) samp[r*4 + j] = h1[r*4 + j];
        if (j == 3) frame_due = 1;
      end
      h1 = h0;
      h0 = keys;
    end
    @(negedge clk);
    exp_col = ~(4'b0001 << ((n / SD) % 4));
    chk("col", col, exp_col);
    chk("key_code", key_code, e_code);
    chk("key_held", {3'b0, key_held}, {3'b0, m_held});
    chk("key_press", {3'b0, key_press}, {3'b0, e_press});
    if (key_press === 1'b1) pulses++;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    int b0, b1, sel;
    pulses = 0;
    // reset and idle rotation
    rst = 1'b1; run(3);
    rst = 1'b0; run(2 * FRAME);
    chk("idle_pulses", 4'(pulses), 4'd0);

    // single press of '5', long hold, then release
    keys = 16'(1) << 5;
    pulses = 0; run(13 * FRAME);
    chk("hold5_pulses", 4'(pulses), 4'd1);
    chk("hold5_code", key_code, 4'h5);
    chk("hold5_held", {3'b0, key_held}, 4'd1);
    keys = '0; run(5 * FRAME);
    chk("rel5_held", {3'b0, key_held}, 4'd0);
    chk("rel5_code", key_code, 4'h5);

    // bounce on 'E', then steady hold
    pulses = 0;
    for (int i = 0; i < 8 * FRAME; i++) begin
      if (i % 10 == 0) keys[14] = ~keys[14];
      tick();
    end
    keys = 16'(1) << 14; run(5 * FRAME);
    chk("bounceE_code", key_code, 4'hE);
    keys = '0; run(5 * FRAME);

    // 'A' with '0' together: no change
    keys = (16'(1) << 3) | (16'(1) << 12); pulses = 0; run(6 * FRAME);
    chk("multi_pulses", 4'(pulses), 4'd0);
    keys = '0; run(4 * FRAME);

    // rollover '1' -> '1'+'D' -> 'D'
    keys = 16'(1) << 0;  run(5 * FRAME);
    keys = keys | (16'(1) << 15); run(2 * FRAME);
    keys = 16'(1) << 15; run(5 * FRAME);
    chk("roll_code", key_code, 4'hD);
    chk("roll_held", {3'b0, key_held}, 4'd1);
    keys = '0; run(5 * FRAME);

    // reset mid-operation while 'C' is held
    keys = 16'(1) << 11; run(5 * FRAME + 7);
    rst = 1'b1; run(1);
    rst = 1'b0; run(5 * FRAME);
    chk("rstC_code", key_code, 4'hC);
    keys = '0; run(5 * FRAME);

    // randomized key patterns and hold lengths
    for (int s = 0; s < 60; s++) begin
      sel = $urandom_range(0, 4);
      b0 = $urandom_range(0, 15);
      b1 = $urandom_range(0, 15);
      case (sel)
        0:       keys = '0;
        3:       keys = (16'(1) << b0) | (16'(1) << b1);
        default: keys = 16'(1) << b0;
      endcase
      run($urandom_range(1, 5 * FRAME));
    end
    keys = '0; run(5 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
